mdio_master: RTL and testbench

Parametrised MDIO (IEEE 802.3 management) master serialising Clause 22 and Clause 45 management frames onto MDC/MDIO from a valid/ready command interface. It generates MDC internally from i_clk by a programmable divider and emits a configurable preamble. It checks read turnaround for a non-responding PHY. It sits between the MAC/host control-register block and the board-level MDIO pad; the pad tristate buffer lives outside this block.

---
 rtl/mdio_master_if.sv | 25 ++
 rtl/mdio_master.sv | 209 ++++++++++++++++++++
 tb/tb_mdio_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_master_if.sv
// Command/response bus between the host register block and the MDIO master.
interface mdio_master_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_c45;
    logic [1:0]  i_op;
    logic [4:0]  i_phy_addr;
    logic [4:0]  i_reg_addr;
    logic [15:0] i_wdata;
    logic [15:0] o_rdata;
    logic        o_rdata_valid;
    logic        o_read_err;
    logic        o_cmd_err;
    logic        o_busy;

    modport slave (
        input  i_req_valid, i_c45, i_op, i_phy_addr, i_reg_addr, i_wdata,
        output o_req_ready, o_rdata, o_rdata_valid, o_read_err, o_cmd_err, o_busy
    );

    modport master (
        output i_req_valid, i_c45, i_op, i_phy_addr, i_reg_addr, i_wdata,
        input  o_req_ready, o_rdata, o_rdata_valid, o_read_err, o_cmd_err, o_busy
    );
endinterface

// File: rtl/mdio_master.sv
// MDIO management master: serialises Clause 22/45 frames onto MDC/MDIO with an
// internally divided MDC, optional preamble and read turnaround checking.
module mdio_master #(
    parameter int CLK_DIV       = 10,
    parameter int PREAMBLE_BITS = 32,
    parameter int C45_EN        = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    mdio_master_if.slave  bus,
    output logic          o_mdc,
    output logic          o_mdio_o,
    output logic          o_mdio_oe,
    input  logic          i_mdio_i
);

    localparam int MAXB = (PREAMBLE_BITS > 16) ? PREAMBLE_BITS : 16;
    localparam int CW   = $clog2(MAXB);
    localparam int DW   = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA, GAP
    } state_t;

    function automatic logic [CW-1:0] field_last(input state_t s);
        case (s)
            PRE:         field_last = CW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
            ST, OP, TA:  field_last = CW'(1);
            PHYAD, REGAD: field_last = CW'(4);
            DATA:        field_last = CW'(15);
            default:     field_last = '0;
        endcase
    endfunction

    function automatic state_t field_next(input state_t s);
        case (s)
            IDLE:    field_next = (PREAMBLE_BITS > 0) ? PRE : ST;
            PRE:     field_next = ST;
            ST:      field_next = OP;
            OP:      field_next = PHYAD;
            PHYAD:   field_next = REGAD;
            REGAD:   field_next = TA;
            TA:      field_next = DATA;
            DATA:    field_next = GAP;
            default: field_next = IDLE;
        endcase
    endfunction

    state_t          state, state_nxt;
    logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [DW-1:0]   div_cnt;
    logic            rst_q;

    logic            c45_q, rd_q;
    logic [1:0]      op_q;
    logic [4:0]      phy_q, reg_q;
    logic [15:0]     wdata_q, shreg, rdata_q;
    logic            err_q, rdata_valid_q, read_err_q, cmd_err_q;

    logic            accept, c45_in, rd_in, legal_in, start, bad;
    logic            half_end, low_end, high_end, launch;
    logic            f_c45, f_rd;
    logic [1:0]      f_op;
    logic [4:0]      f_phy, f_reg;
    logic [15:0]     f_wdata;
    logic            drv_o, drv_oe;

    assign accept   = bus.i_req_valid && bus.o_req_ready;
    assign c45_in   = bus.i_c45 && (C45_EN != 0);
    assign rd_in    = c45_in ? bus.i_op[1] : (bus.i_op == 2'b10);
    assign legal_in = c45_in || (bus.i_op == 2'b01) || (bus.i_op == 2'b10);
    assign start    = accept && legal_in;
    assign bad      = accept && !legal_in;

    assign half_end = (state != IDLE) && (div_cnt == DW'(CLK_DIV - 1));
    assign low_end  = half_end && !o_mdc;
    assign high_end = half_end && o_mdc;
    assign launch   = start || high_end;

    // The first bit is launched on the accept edge, before the fields are latched.
    assign f_c45   = start ? c45_in          : c45_q;
    assign f_rd    = start ? rd_in           : rd_q;
    assign f_op    = start ? bus.i_op        : op_q;
    assign f_phy   = start ? bus.i_phy_addr  : phy_q;
    assign f_reg   = start ? bus.i_reg_addr  : reg_q;
    assign f_wdata = start ? bus.i_wdata     : wdata_q;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        drv_o       = 1'b1;
        drv_oe      = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_nxt   = field_next(IDLE);
                bit_cnt_nxt = field_last(state_nxt);
            end
        end else if (high_end) begin
            if (bit_cnt == '0) begin
                state_nxt   = field_next(state);
                bit_cnt_nxt = field_last(state_nxt);
            end else begin
                bit_cnt_nxt = bit_cnt - 1'b1;
            end
        end
        case (state_nxt)
            PRE: begin
                drv_o  = 1'b1;
                drv_oe = 1'b1;
            end
            ST: begin
                drv_o  = bit_cnt_nxt[0] ? 1'b0 : ~f_c45;
                drv_oe = 1'b1;
            end
            OP: begin
                drv_o  = f_op[bit_cnt_nxt[0]];
                drv_oe = 1'b1;
            end
            PHYAD: begin
                drv_o  = f_phy[bit_cnt_nxt[2:0]];
                drv_oe = 1'b1;
            end
            REGAD: begin
                drv_o  = f_reg[bit_cnt_nxt[2:0]];
                drv_oe = 1'b1;
            end
            TA: if (!f_rd) begin
                drv_o  = bit_cnt_nxt[0];
                drv_oe = 1'b1;
            end
            DATA: if (!f_rd) begin
                drv_o  = f_wdata[bit_cnt_nxt[3:0]];
                drv_oe = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rst_q         <= 1'b1;
            div_cnt       <= '0;
            o_mdc         <= 1'b0;
            o_mdio_o      <= 1'b1;
            o_mdio_oe     <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            read_err_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            rst_q         <= 1'b0;
            cmd_err_q     <= bad;
            rdata_valid_q <= 1'b0;
            read_err_q    <= 1'b0;
            if (start)
                div_cnt <= '0;
            else if (state != IDLE)
                div_cnt <= half_end ? '0 : div_cnt + 1'b1;
            if (launch) begin
                o_mdc     <= 1'b0;
                o_mdio_o  <= drv_o;
                o_mdio_oe <= drv_oe;
            end else if (low_end) begin
                o_mdc <= 1'b1;
            end
            if (high_end && state == DATA && bit_cnt == '0 && rd_q) begin
                rdata_q       <= shreg;
                rdata_valid_q <= 1'b1;
                read_err_q    <= err_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (start) begin
            c45_q   <= c45_in;
            rd_q    <= rd_in;
            op_q    <= bus.i_op;
            phy_q   <= bus.i_phy_addr;
            reg_q   <= bus.i_reg_addr;
            wdata_q <= bus.i_wdata;
        end
        // The pad is sampled as MDC rises; TA bit 2 must be pulled low by the PHY.
        if (low_end && rd_q) begin
            if (state == TA && bit_cnt == '0)
                err_q <= i_mdio_i;
            if (state == DATA)
                shreg <= {shreg[14:0], i_mdio_i};
        end
    end

    assign bus.o_req_ready   = (state == IDLE) && !rst_q;
    assign bus.o_busy        = (state != IDLE);
    assign bus.o_rdata       = rdata_q;
    assign bus.o_rdata_valid = rdata_valid_q;
    assign bus.o_read_err    = read_err_q;
    assign bus.o_cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two builds (32-bit and no preamble) driven by directed
// and random commands, checked against a frame model built from the field rules.
module tb_mdio_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel, req_valid, c45, mdio_in;
    logic [1:0]  op;
    logic [4:0]  phy, regad;
    logic [15:0] wdata;
    logic        mdc_a, o_a, oe_a, mdc_b, o_b, oe_b;

    mdio_master_if ifa();
    mdio_master_if ifb();

    assign ifa.i_req_valid = req_valid & ~sel;
    assign ifa.i_c45       = c45;
    assign ifa.i_op        = op;
    assign ifa.i_phy_addr  = phy;
    assign ifa.i_reg_addr  = regad;
    assign ifa.i_wdata     = wdata;
    assign ifb.i_req_valid = req_valid & sel;
    assign ifb.i_c45       = c45;
    assign ifb.i_op        = op;
    assign ifb.i_phy_addr  = phy;
    assign ifb.i_reg_addr  = regad;
    assign ifb.i_wdata     = wdata;

    mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(32), .C45_EN(1)) dut_a (
        .i_clk(clk), .i_reset(rst), .bus(ifa),
        .o_mdc(mdc_a), .o_mdio_o(o_a), .o_mdio_oe(oe_a), .i_mdio_i(mdio_in)
    );

    mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(0), .C45_EN(1)) dut_b (
        .i_clk(clk), .i_reset(rst), .bus(ifb),
        .o_mdc(mdc_b), .o_mdio_o(o_b), .o_mdio_oe(oe_b), .i_mdio_i(mdio_in)
    );

    logic        s_mdc, s_o, s_oe, s_ready, s_busy, s_rvld, s_rerr, s_cerr;
    logic [15:0] s_rdata;
    assign s_mdc   = sel ? mdc_b : mdc_a;
    assign s_o     = sel ? o_b : o_a;
    assign s_oe    = sel ? oe_b : oe_a;
    assign s_ready = sel ? ifb.o_req_ready : ifa.o_req_ready;
    assign s_busy  = sel ? ifb.o_busy : ifa.o_busy;
    assign s_rvld  = sel ? ifb.o_rdata_valid : ifa.o_rdata_valid;
    assign s_rerr  = sel ? ifb.o_read_err : ifa.o_read_err;
    assign s_cerr  = sel ? ifb.o_cmd_err : ifa.o_cmd_err;
    assign s_rdata = sel ? ifb.o_rdata : ifa.o_rdata;

    int vecs = 0;
    int errs = 0;

    // Drives one command and checks every cycle of the frame against a model
    // of the expected line, busy/ready timing and read result.
    task automatic run_frame(input logic s, input logic fc45, input logic [1:0] fop,
                             input logic [4:0] fphy, input logic [4:0] freg,
                             input logic [15:0] fwd, input logic resp_en,
                             input logic [15:0] resp, input logic resp_ta,
                             input logic noise);
        int pre, n, k, ph, q;
        logic rd, exp_busy, exp_mdc, exp_rvld, exp_err;
        logic [15:0] exp_rd;
        logic [31:0] word;
        logic eo[$];
        logic eoe[$];
        logic line[$];
        pre  = s ? 0 : 32;
        n    = pre + 32;
        rd   = fc45 ? fop[1] : (fop == 2'b10);
        word = {1'b0, ~fc45, fop, fphy, freg, (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : fwd)};
        for (int p = 0; p < n; p++) begin
            if (p < pre) begin
                eo.push_back(1'b1); eoe.push_back(1'b1); line.push_back(1'b1);
            end else begin
                q = p - pre;
                eoe.push_back(!(rd && q >= 14));
                eo.push_back(word[31-q]);
                if (rd && resp_en && q == 15)      line.push_back(resp_ta);
                else if (rd && resp_en && q >= 16) line.push_back(resp[31-q]);
                else                               line.push_back(1'b1);
            end
        end
        exp_rd  = resp_en ? resp : 16'hFFFF;
        exp_err = resp_en ? resp_ta : 1'b1;

        sel = s;
        vecs++;
        if (s_ready !== 1'b1) begin
            errs++; $display("FAIL ready_before_cmd got %b want 1", s_ready);
        end
        c45 = fc45; op = fop; phy = fphy; regad = freg; wdata = fwd; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= (n + 1) * 4 + 1; c++) begin
            if (c > 1) @(negedge clk);
            k  = (c - 1) / 4;
            ph = (c - 1) % 4;
            if (noise) begin
                if (c < n * 4) begin
                    req_valid = 1'b1;
                    c45 = 1'($urandom); op = 2'($urandom); phy = 5'($urandom);
                    regad = 5'($urandom); wdata = 16'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
            end
            exp_busy = (c <= (n + 1) * 4);
            exp_mdc  = exp_busy && (ph >= 2);
            exp_rvld = rd && (c == n * 4 + 1);
            vecs += 5;
            if (s_busy !== exp_busy) begin
                errs++; $display("FAIL busy c=%0d got %b want %b", c, s_busy, exp_busy);
            end
            if (s_ready !== !exp_busy) begin
                errs++; $display("FAIL ready c=%0d got %b want %b", c, s_ready, !exp_busy);
            end
            if (s_mdc !== exp_mdc) begin
                errs++; $display("FAIL mdc c=%0d got %b want %b", c, s_mdc, exp_mdc);
            end
            if (s_rvld !== exp_rvld) begin
                errs++; $display("FAIL rdata_valid c=%0d got %b want %b", c, s_rvld, exp_rvld);
            end
            if (s_cerr !== 1'b0) begin
                errs++; $display("FAIL cmd_err c=%0d got %b want 0", c, s_cerr);
            end
            if (k < n) begin
                vecs += 2;
                if (s_oe !== eoe[k]) begin
                    errs++; $display("FAIL mdio_oe bit=%0d got %b want %b", k, s_oe, eoe[k]);
                end
                if (s_o !== (eoe[k] ? eo[k] : 1'b1)) begin
                    errs++; $display("FAIL mdio_o bit=%0d got %b want %b", k, s_o, eoe[k] ? eo[k] : 1'b1);
                end
                if (ph == 0) mdio_in = line[k];
            end else if (exp_busy) begin
                vecs += 2;
                if (s_oe !== 1'b0) begin
                    errs++; $display("FAIL gap_oe c=%0d got %b want 0", c, s_oe);
                end
                if (s_o !== 1'b1) begin
                    errs++; $display("FAIL gap_mdio_o c=%0d got %b want 1", c, s_o);
                end
                mdio_in = 1'b1;
            end
            if (exp_rvld) begin
                vecs += 2;
                if (s_rdata !== exp_rd) begin
                    errs++; $display("FAIL rdata got %h want %h", s_rdata, exp_rd);
                end
                if (s_rerr !== exp_err) begin
                    errs++; $display("FAIL read_err got %b want %b", s_rerr, exp_err);
                end
            end
        end
        mdio_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; sel = 1'b0; mdio_in = 1'b1;
        c45 = 1'b0; op = 2'b00; phy = '0; regad = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs += 9;
        if (s_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b want 0", s_ready); end
        if (s_busy !== 1'b0)  begin errs++; $display("FAIL rst_busy got %b want 0", s_busy); end
        if (s_mdc !== 1'b0)   begin errs++; $display("FAIL rst_mdc got %b want 0", s_mdc); end
        if (s_oe !== 1'b0)    begin errs++; $display("FAIL rst_oe got %b want 0", s_oe); end
        if (s_o !== 1'b1)     begin errs++; $display("FAIL rst_mdio_o got %b want 1", s_o); end
        if (s_rdata !== 16'h0) begin errs++; $display("FAIL rst_rdata got %h want 0", s_rdata); end
        if (s_rvld !== 1'b0)  begin errs++; $display("FAIL rst_rvld got %b want 0", s_rvld); end
        if (s_rerr !== 1'b0)  begin errs++; $display("FAIL rst_rerr got %b want 0", s_rerr); end
        if (s_cerr !== 1'b0)  begin errs++; $display("FAIL rst_cerr got %b want 0", s_cerr); end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (s_ready !== 1'b1) begin errs++; $display("FAIL ready_after_rst got %b want 1", s_ready); end
    endtask

    task automatic test_c22_write();
        run_frame(1'b0, 1'b0, 2'b01, 5'h01, 5'h04, 16'h01E1, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_c22_read();
        run_frame(1'b0, 1'b0, 2'b10, 5'h1F, 5'h02, 16'h0, 1'b1, 16'h0141, 1'b0, 1'b0);
    endtask

    task automatic test_c45_no_responder();
        run_frame(1'b0, 1'b1, 2'b11, 5'h03, 5'h01, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_cmd_err();
        logic [1:0] bad_ops [2];
        bad_ops[0] = 2'b00;
        bad_ops[1] = 2'b11;
        sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c45 = 1'b0; op = bad_ops[i]; req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            vecs += 4;
            if (s_cerr !== 1'b1)  begin errs++; $display("FAIL cmd_err_pulse op=%b got %b want 1", op, s_cerr); end
            if (s_ready !== 1'b1) begin errs++; $display("FAIL cmd_err_ready got %b want 1", s_ready); end
            if (s_busy !== 1'b0)  begin errs++; $display("FAIL cmd_err_busy got %b want 0", s_busy); end
            if (s_mdc !== 1'b0)   begin errs++; $display("FAIL cmd_err_mdc got %b want 0", s_mdc); end
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                vecs += 3;
                if (s_cerr !== 1'b0)  begin errs++; $display("FAIL cmd_err_hold c=%0d got %b want 0", c, s_cerr); end
                if (s_mdc !== 1'b0)   begin errs++; $display("FAIL cmd_err_mdc_hold c=%0d got %b want 0", c, s_mdc); end
                if (s_ready !== 1'b1) begin errs++; $display("FAIL cmd_err_ready_hold c=%0d got %b want 1", c, s_ready); end
            end
        end
    endtask

    task automatic test_no_preamble();
        run_frame(1'b1, 1'b1, 2'b00, 5'h07, 5'h03, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic s, fc45, re, rta, nz;
        logic [1:0] fop;
        for (int i = 0; i < 8; i++) begin
            s    = 1'($urandom);
            fc45 = 1'($urandom);
            fop  = fc45 ? 2'($urandom) : (($urandom % 2) != 0 ? 2'b01 : 2'b10);
            re   = 1'($urandom);
            rta  = 1'($urandom);
            nz   = 1'($urandom);
            run_frame(s, fc45, fop, 5'($urandom), 5'($urandom), 16'($urandom),
                      re, 16'($urandom), rta, nz);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 1'b0, 2'b10, 5'h11, 5'h1E, 16'h0, 1'b1, 16'hA55A, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 2'b01, 5'h02, 5'h1D, 16'h5AA5, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        sel = 1'b0; c45 = 1'b0; op = 2'b10; phy = 5'h05; regad = 5'h01; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mdio_in = 1'b0;
        repeat ((32 + 20) * 4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vecs += 7;
        if (s_mdc !== 1'b0)    begin errs++; $display("FAIL abort_mdc got %b want 0", s_mdc); end
        if (s_oe !== 1'b0)     begin errs++; $display("FAIL abort_oe got %b want 0", s_oe); end
        if (s_o !== 1'b1)      begin errs++; $display("FAIL abort_mdio_o got %b want 1", s_o); end
        if (s_busy !== 1'b0)   begin errs++; $display("FAIL abort_busy got %b want 0", s_busy); end
        if (s_rvld !== 1'b0)   begin errs++; $display("FAIL abort_rvld got %b want 0", s_rvld); end
        if (s_rdata !== 16'h0) begin errs++; $display("FAIL abort_rdata got %h want 0", s_rdata); end
        if (s_ready !== 1'b0)  begin errs++; $display("FAIL abort_ready got %b want 0", s_ready); end
        rst = 1'b0;
        mdio_in = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vecs += 3;
            if (s_rvld !== 1'b0) begin errs++; $display("FAIL post_abort_rvld c=%0d got %b want 0", c, s_rvld); end
            if (s_busy !== 1'b0) begin errs++; $display("FAIL post_abort_busy c=%0d got %b want 0", c, s_busy); end
            if (s_mdc !== 1'b0)  begin errs++; $display("FAIL post_abort_mdc c=%0d got %b want 0", c, s_mdc); end
        end
        run_frame(1'b0, 1'b0, 2'b10, 5'h05, 5'h01, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_c22_write();
        test_c22_read();
        test_c45_no_responder();
        test_cmd_err();
        test_no_preamble();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
